tt_bist_seq: RTL

On-chip built-in self-test sequencer for the tt_um_top datapath. It takes the stimulus side of the pin interface: drives operand and mode patterns onto the design's dedicated and bidirectional input buses, and reads back the dedicated outputs. It checks the adder and half-latch functions against internally computed expectations. It reports pass/fail, a failure count and the first failing vector, so silicon can be checked without an external tester.

---
 rtl/tt_bist_seq_if.sv | 23 ++
 rtl/tt_bist_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_bist_seq_if.sv
// Pin-side bus between the BIST sequencer and the tt_um_top datapath, plus run status.
// The master modport is the sequencer; the slave modport is the DUT/environment side.
interface tt_bist_seq_if;
  logic       start;
  logic [7:0] dut_ui;
  logic [7:0] dut_uio;
  logic [7:0] dut_uo;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] fail_count;
  logic [7:0] fail_idx;

  modport master (
    input  start, dut_uo,
    output dut_ui, dut_uio, busy, done, pass, fail_count, fail_idx
  );

  modport slave (
    output start, dut_uo,
    input  dut_ui, dut_uio, busy, done, pass, fail_count, fail_idx
  );
endinterface

// File: rtl/tt_bist_seq.sv
// Built-in self-test sequencer: walks adder vectors then half-latch lanes on tt_um_top,
// comparing dut_uo against internally generated expectations and logging failures.
module tt_bist_seq #(
  parameter int N_VEC  = 16,
  parameter int SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  tt_bist_seq_if.master bus
);

  typedef enum logic [3:0] {
    IDLE,
    A_DRIVE,
    A_WAIT,
    A_CHECK,
    L_WRITE,
    L_HOLD,
    L_CLR,
    L_WAIT,
    L_CHECK,
    FIN
  } state_t;

  state_t     state;
  logic [6:0] vec_idx;
  logic [2:0] latch_step;
  logic [3:0] wait_cnt;
  logic [7:0] ui_q;
  logic [7:0] uio_q;
  logic [7:0] fail_count_q;
  logic [7:0] fail_idx_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;

  logic [1:0] lane;
  logic       lane_d;
  logic [6:0] next_vec;
  logic [2:0] next_step;
  logic       next_d;
  logic [7:0] expected_sum;
  logic [7:0] check_index;
  logic       mismatch;

  function automatic logic [7:0] adder_ui(input logic [6:0] idx);
    logic [5:0] a;
    a = idx[5:0] * 6'd5 + 6'd2;
    return {2'b00, a};
  endfunction

  function automatic logic [7:0] adder_uio(input logic [6:0] idx);
    return {idx[0], idx} ^ 8'h05;
  endfunction

  // Mode bit 6 selects the latch path; only the lane's data bit is ever set.
  function automatic logic [7:0] latch_ui(input logic [1:0] k, input logic d);
    return 8'h40 | ({7'd0, d} << k);
  endfunction

  assign lane      = latch_step[2:1];
  assign lane_d    = latch_step[1] ^ latch_step[0];
  assign next_vec  = vec_idx + 7'd1;
  assign next_step = latch_step + 3'd1;
  assign next_d    = next_step[1] ^ next_step[0];

  always_comb begin
    expected_sum = adder_ui(vec_idx) + adder_uio(vec_idx);
    mismatch     = 1'b0;
    check_index  = {1'b0, vec_idx};
    if (state == A_CHECK) begin
      mismatch = (bus.dut_uo != expected_sum);
    end else if (state == L_CHECK) begin
      mismatch    = (bus.dut_uo[lane] != lane_d);
      check_index = 8'(N_VEC) + {5'd0, latch_step};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      vec_idx      <= '0;
      latch_step   <= '0;
      wait_cnt     <= '0;
      ui_q         <= '0;
      uio_q        <= '0;
      fail_count_q <= '0;
      fail_idx_q   <= 8'hFF;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      // Failures are only ever flagged in a CHECK state, so this never races the IDLE clear.
      if (mismatch) begin
        if (fail_count_q != 8'hFF) fail_count_q <= fail_count_q + 8'd1;
        if (fail_idx_q == 8'hFF)   fail_idx_q   <= check_index;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= A_DRIVE;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= '0;
            fail_idx_q   <= 8'hFF;
            vec_idx      <= '0;
            ui_q         <= adder_ui(7'd0);
            uio_q        <= adder_uio(7'd0);
          end
        end

        A_DRIVE: begin
          if (SETTLE == 0) begin
            state <= A_CHECK;
          end else begin
            state    <= A_WAIT;
            wait_cnt <= 4'(SETTLE - 1);
          end
        end

        A_WAIT: begin
          if (wait_cnt == 4'd0) state <= A_CHECK;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end

        A_CHECK: begin
          if (vec_idx == 7'(N_VEC - 1)) begin
            state      <= L_WRITE;
            latch_step <= '0;
            ui_q       <= latch_ui(2'd0, 1'b0);
            uio_q      <= 8'h01;
          end else begin
            state   <= A_DRIVE;
            vec_idx <= next_vec;
            ui_q    <= adder_ui(next_vec);
            uio_q   <= adder_uio(next_vec);
          end
        end

        L_WRITE: state <= L_HOLD;

        // Drop the enable and flip the data so only a retained value passes.
        L_HOLD: begin
          state <= L_CLR;
          ui_q  <= latch_ui(lane, ~lane_d);
          uio_q <= '0;
        end

        L_CLR: begin
          if (SETTLE == 0) begin
            state <= L_CHECK;
          end else begin
            state    <= L_WAIT;
            wait_cnt <= 4'(SETTLE - 1);
          end
        end

        L_WAIT: begin
          if (wait_cnt == 4'd0) state <= L_CHECK;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end

        L_CHECK: begin
          if (latch_step == 3'd7) begin
            state <= FIN;
            ui_q  <= '0;
            uio_q <= '0;
          end else begin
            state      <= L_WRITE;
            latch_step <= next_step;
            ui_q       <= latch_ui(next_step[2:1], next_d);
            uio_q      <= 8'b1 << next_step[2:1];
          end
        end

        FIN: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          pass_q <= (fail_count_q == 8'd0);
          ui_q   <= '0;
          uio_q  <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dut_ui     = ui_q;
  assign bus.dut_uio    = uio_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail_count = fail_count_q;
  assign bus.fail_idx   = fail_idx_q;

endmodule
